// File: rtl/light_frame_rx_pkg.sv
// Shared definitions for the optical receive path: frame geometry, line levels
// and receiver state encoding.
package light_frame_rx_pkg;

   localparam int unsigned FRAME_SIZE          = 16;
   localparam int unsigned SAMPLES_PER_BIT_DEF = 8;

   localparam logic LINE_IDLE  = 1'b0;
   localparam logic LINE_START = 1'b1;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/light_frame_rx_line_sync.sv
// Two-flop synchroniser for an asynchronous line plus a one-cycle history
// register for edge detection; shared with the transmit-side loopback monitor.
module line_sync (
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic line_s,
   output logic line_prev
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta      <= '0;
         line_s    <= '0;
         line_prev <= '0;
      end else begin
         meta      <= line;
         line_s    <= meta;
         line_prev <= line_s;
      end
   end

endmodule

// File: rtl/light_frame_rx.sv
// Optical link receiver: oversampled start detection, LSB-first deserialisation
// of one codeword, stop-bit check and a held output frame with ack handshake.
module light_frame_rx
   import light_frame_rx_pkg::*;
#(
   parameter int unsigned SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
   parameter int unsigned FRAME_BITS      = FRAME_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_in,
   output logic [FRAME_BITS-1:0] frame,
   output logic                  frame_valid,
   input  logic                  frame_ack,
   output logic                  busy,
   output logic                  framing_error,
   output logic                  overrun
);

   localparam int unsigned CW = $clog2(SAMPLES_PER_BIT);
   localparam int unsigned BW = $clog2(FRAME_BITS + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES_PER_BIT - 1);
   // START is entered one cycle after T0, so the mid-bit sample lands at count H-2
   localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLES_PER_BIT / 2 - 2);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

   rx_state_t state, state_nxt;

   logic                  rx_s;
   logic                  rx_prev;
   logic [CW-1:0]         cnt;
   logic [BW-1:0]         bit_cnt;
   logic [FRAME_BITS-1:0] shreg;

   logic start_edge;
   logic start_sample;
   logic bit_sample;
   logic stop_sample;
   logic deliver;
   logic frame_bad;

   line_sync u_sync (
      .clk       (clk),
      .reset     (reset),
      .line      (rx_in),
      .line_s    (rx_s),
      .line_prev (rx_prev)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RX_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE: begin
            if (rx_s == LINE_START && rx_prev == LINE_IDLE) begin
               state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (cnt == CNT_HALF) begin
               state_nxt = (rx_s == LINE_START) ? RX_DATA : RX_IDLE;
            end
         end
         RX_DATA: begin
            if (cnt == CNT_LAST && bit_cnt == BIT_LAST) begin
               state_nxt = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == CNT_LAST) begin
               state_nxt = RX_IDLE;
            end
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   // Output / strobe decode
   always_comb begin
      start_edge   = (state == RX_IDLE) && (rx_s == LINE_START) && (rx_prev == LINE_IDLE);
      start_sample = (state == RX_START) && (cnt == CNT_HALF);
      bit_sample   = (state == RX_DATA) && (cnt == CNT_LAST);
      stop_sample  = (state == RX_STOP) && (cnt == CNT_LAST);
      deliver      = stop_sample && (rx_s == LINE_IDLE);
      frame_bad    = stop_sample && (rx_s != LINE_IDLE);
      busy         = (state != RX_IDLE);
   end

   // Sample counter: re-phased at the start-bit midpoint, then one full bit per wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         case (state)
            RX_IDLE:  cnt <= '0;
            RX_START: cnt <= start_sample ? '0 : cnt + 1'b1;
            default:  cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt <= '0;
      end else if (state != RX_DATA) begin
         bit_cnt <= '0;
      end else if (bit_sample) begin
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || frame_bad || start_edge) begin
         shreg <= '0;
      end else if (bit_sample) begin
         shreg <= {rx_s, shreg[FRAME_BITS-1:1]};
      end
   end

   // Ack coinciding with delivery frees the slot for the new frame
   always_ff @(posedge clk) begin
      if (reset) begin
         frame         <= '0;
         frame_valid   <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= frame_bad;
         overrun       <= deliver && frame_valid && !frame_ack;
         if (deliver && (!frame_valid || frame_ack)) begin
            frame       <= shreg;
            frame_valid <= 1'b1;
         end else if (!deliver && frame_valid && frame_ack) begin
            frame_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_light_frame_rx.sv
// Bench for light_frame_rx: directed scenarios plus random traffic, every cycle
// checked against a timing-formula model of the receiver.
module tb_light_frame_rx;

   localparam int SPB = 8;
   localparam int FB  = 16;
   localparam int H   = SPB / 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_in;
   logic [FB-1:0] frame;
   logic          frame_valid;
   logic          frame_ack;
   logic          busy;
   logic          framing_error;
   logic          overrun;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   light_frame_rx #(
      .SAMPLES_PER_BIT (SPB),
      .FRAME_BITS      (FB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_in         (rx_in),
      .frame         (frame),
      .frame_valid   (frame_valid),
      .frame_ack     (frame_ack),
      .busy          (busy),
      .framing_error (framing_error),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input logic [FB-1:0] got, input logic [FB-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks T0 and derives every sample instant as T0+H-1+n*SPB.
   logic          m_s1, m_s2, m_prev;
   logic          m_active;
   int            m_t0;
   logic [FB-1:0] m_bits;
   logic [FB-1:0] m_frame;
   logic          m_valid, m_busy, m_ferr, m_ovr;
   logic          chk_en = 1'b0;

   always @(negedge clk) begin
      int   d, k;
      logic rs, dlv, ferr_n, ovr_n;
      if (chk_en) begin
         cmp("frame",         frame,         m_frame);
         cmp("frame_valid",   frame_valid,   m_valid);
         cmp("busy",          busy,          m_busy);
         cmp("framing_error", framing_error, m_ferr);
         cmp("overrun",       overrun,       m_ovr);
      end
      rs = m_s2; dlv = 1'b0; ferr_n = 1'b0; ovr_n = 1'b0;
      if (reset) begin
         m_s1 = 0; m_s2 = 0; m_prev = 0; m_active = 0; m_t0 = 0; m_bits = '0;
         m_frame = '0; m_valid = 0; m_busy = 0; m_ferr = 0; m_ovr = 0;
         chk_en = 1'b1;
      end else begin
         if (!m_active) begin
            if (rs && !m_prev) begin
               m_active = 1'b1;
               m_t0     = cyc;
            end
         end else begin
            d = cyc - m_t0;
            if (d == H - 1) begin
               if (!rs) m_active = 1'b0;
            end else if (d > H - 1 && (d - (H - 1)) % SPB == 0) begin
               k = (d - (H - 1)) / SPB - 1;
               if (k < FB) begin
                  m_bits[k] = rs;
               end else begin
                  m_active = 1'b0;
                  if (rs) ferr_n = 1'b1;
                  else    dlv    = 1'b1;
               end
            end
         end
         if (dlv) begin
            if (!m_valid || frame_ack) begin
               m_frame = m_bits;
               m_valid = 1'b1;
            end else begin
               ovr_n = 1'b1;
            end
         end else if (m_valid && frame_ack) begin
            m_valid = 1'b0;
         end
         m_busy = m_active;
         m_ferr = ferr_n;
         m_ovr  = ovr_n;
         m_prev = m_s2;
         m_s2   = m_s1;
         m_s1   = rx_in;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic v);
      rx_in = v;
      step(SPB);
   endtask

   task automatic send(input logic [FB-1:0] data, input logic stopb);
      drive_bit(1'b1);
      for (int i = 0; i < FB; i++) drive_bit(data[i]);
      drive_bit(stopb);
   endtask

   task automatic at_neg(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_ack();
      frame_ack = 1'b1;
      step(1);
      frame_ack = 1'b0;
   endtask

   logic [FB-1:0] got0, got1;
   logic          rdone;

   initial begin
      int s, s2;
      reset = 1'b1; rx_in = 1'b0; frame_ack = 1'b0; rdone = 1'b0;
      step(3);
      reset = 1'b0;
      @(negedge clk);
      cmp("rst_frame", frame, 16'h0000);
      cmp("rst_valid", frame_valid, 1'b0);
      cmp("rst_busy", busy, 1'b0);
      step(20);

      // 1: basic frame, ack two cycles after valid
      s = cyc;
      fork
         send(16'hA5C3, 1'b0);
         begin
            at_neg(s + 141); cmp("t1_valid_early", frame_valid, 1'b0);
            at_neg(s + 142); cmp("t1_valid", frame_valid, 1'b1);
            cmp("t1_frame", frame, 16'hA5C3);
         end
      join
      rx_in = 1'b0;
      pulse_ack();
      at_neg(s + 145);
      cmp("t1_valid_fall", frame_valid, 1'b0);
      cmp("t1_frame_hold", frame, 16'hA5C3);
      step(20);

      // 2: two-cycle glitch
      s = cyc;
      rx_in = 1'b1; step(2); rx_in = 1'b0;
      at_neg(s + 3); cmp("t2_busy", busy, 1'b1);
      at_neg(s + 6); cmp("t2_busy_drop", busy, 1'b0);
      step(30);

      // 3: stop bit 1, line stays high afterwards
      s = cyc;
      fork
         send(16'h0001, 1'b1);
         begin
            at_neg(s + 142);
            cmp("t3_ferr", framing_error, 1'b1);
            cmp("t3_valid", frame_valid, 1'b0);
            cmp("t3_frame", frame, 16'hA5C3);
            at_neg(s + 143); cmp("t3_ferr_pulse", framing_error, 1'b0);
         end
      join
      step(200);
      @(negedge clk); cmp("t3_stuck_busy", busy, 1'b0);
      step(1); rx_in = 1'b0; step(20);

      // 4: overrun, then ack in the delivery cycle
      s = cyc;
      send(16'h1234, 1'b0);
      rx_in = 1'b0;
      at_neg(s + 142); cmp("t4_frame1", frame, 16'h1234);
      step(8);
      s2 = cyc;
      fork
         send(16'hBEEF, 1'b0);
         begin
            at_neg(s2 + 142);
            cmp("t4_overrun", overrun, 1'b1);
            cmp("t4_frame_kept", frame, 16'h1234);
            cmp("t4_valid_kept", frame_valid, 1'b1);
         end
      join
      rx_in = 1'b0; step(8);
      s = cyc;
      fork
         send(16'hBEEF, 1'b0);
         begin
            step(141); pulse_ack();
         end
         begin
            at_neg(s + 142);
            cmp("t4b_frame", frame, 16'hBEEF);
            cmp("t4b_valid", frame_valid, 1'b1);
            cmp("t4b_overrun", overrun, 1'b0);
         end
      join
      rx_in = 1'b0; step(4); pulse_ack(); step(20);

      // 5: reset mid-frame while the line is high
      s = cyc;
      fork
         send(16'h0040, 1'b0);
         begin
            step(62); reset = 1'b1; step(1); reset = 1'b0;
            at_neg(s + 63);
            cmp("t5_frame", frame, 16'h0000);
            cmp("t5_valid", frame_valid, 1'b0);
            cmp("t5_busy", busy, 1'b0);
         end
      join
      rx_in = 1'b0; step(40);
      @(negedge clk); cmp("t5_no_deliver", frame_valid, 1'b0);
      step(1);
      s = cyc;
      send(16'h7FFE, 1'b0);
      rx_in = 1'b0;
      at_neg(s + 145); cmp("t5_frame_new", frame, 16'h7FFE);
      step(1); pulse_ack(); step(20);

      // 6: back-to-back frames with one idle bit
      fork
         begin
            send(16'hFFFF, 1'b0);
            drive_bit(1'b0);
            send(16'h0000, 1'b0);
            rx_in = 1'b0;
         end
         begin
            for (int j = 0; j < 2; j++) begin
               int t;
               t = 0;
               @(negedge clk);
               while (!frame_valid && t < 400) begin
                  @(negedge clk);
                  t++;
               end
               cmp("t6_timeout", (t >= 400), 1'b0);
               if (j == 0) got0 = frame; else got1 = frame;
               @(posedge clk); #1;
               pulse_ack();
            end
         end
      join
      cmp("t6_first", got0, 16'hFFFF);
      cmp("t6_second", got1, 16'h0000);
      step(20);

      // random traffic with random acknowledgement
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               rx_in = 1'b0;
               step($urandom_range(1, 30));
               if ($urandom_range(0, 5) == 0) begin
                  rx_in = 1'b1;
                  step($urandom_range(1, 2));
                  rx_in = 1'b0;
                  step(SPB);
               end
               send(FB'($urandom), ($urandom_range(0, 7) == 0));
               if (rx_in) step($urandom_range(0, 20));
            end
            rx_in = 1'b0;
            step(40);
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk); #1;
               frame_ack = ($urandom_range(0, 3) == 0);
            end
            frame_ack = 1'b0;
         end
      join
      step(5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
